// File: rtl/fsm_arb_pkg.sv
// Shared constants and types for the run-controller round-robin scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fsm_arb_pkg;

    // State encoding of the shared run controller
    localparam logic [1:0] FSM_INIT = 2'd0;
    localparam logic [1:0] FSM_RUN  = 2'd1;
    localparam logic [1:0] FSM_WAIT = 2'd2;
    localparam logic [1:0] FSM_BAD  = 2'd3;

    // Default cycle budget for CHK/HOLD before a fault is declared
    localparam int DEF_TIMEOUT = 15;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_CHK   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } arb_state_e;

endpackage

// File: rtl/fsm.sv
// Shared 3-state run controller (INIT/RUN/WAIT); has no reset by design.
// Latency: one cycle per transition; RUN always lasts one cycle.
// Backpressure: none; start is taken only in INIT, stop only in WAIT.
module fsm
    import fsm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    output logic [1:0] state
);

    logic [1:0] state_q;

    // Controller state register; an illegal code falls back to INIT
    always_ff @(posedge clk) begin
        case (state_q)
            FSM_INIT: if (start) state_q <= FSM_RUN;
            FSM_RUN:  state_q <= mode ? FSM_INIT : FSM_WAIT;
            FSM_WAIT: if (stop) state_q <= FSM_INIT;
            default:  state_q <= FSM_INIT;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/fsm_arb_rr_pick.sv
// Combinational round-robin picker: first set request after the pointer, with wrap.
// Latency: zero cycles (pure combinational).
// Backpressure: none; vld_o low when no request is set.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    idx_o,
    output logic             vld_o
);

    // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the first hit wins
    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!vld_o && req_i[PW'(j)]) begin
                vld_o           = 1'b1;
                idx_o           = PW'(j);
                gnt_o[PW'(j)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_arb.sv
// Round-robin scheduler sequencing one INIT->RUN->(INIT|WAIT->INIT) controller cycle per grant.
// Latency: req sample to fsm_start 1 cycle; done 4 cycles after sample (mode=1), 6+hold (mode=0).
// Backpressure: one grant at a time; new requests wait in IDLE, next START >= 2 cycles after DONE.
module fsm_arb
    import fsm_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int HOLD_W  = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  req_mode,
    input  logic [HOLD_W-1:0] hold,
    input  logic [1:0]        fsm_state,
    output logic              fsm_start,
    output logic              fsm_stop,
    output logic              fsm_mode,
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  done,
    output logic              busy,
    output logic              err
);

    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_e        state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     idx_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  done_q;
    logic [HOLD_W-1:0] hold_q;
    logic [TW-1:0]     tcnt_q;
    logic [TW-1:0]     tcnt_d;
    logic              fsm_start_q;
    logic              fsm_mode_q;
    logic              busy_q;
    logic              err_q;

    logic [N_REQ-1:0]  pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic              pick_vld;
    logic              tmo;
    logic              fault;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // Fault detection: illegal controller code anywhere, or CHK/HOLD overrunning its budget
    always_comb begin
        tcnt_d = tcnt_q + 1'b1;
        tmo    = ((state_q == ST_CHK) || (state_q == ST_HOLD)) && (tcnt_d == TW'(TIMEOUT));
        fault  = (fsm_state == FSM_BAD) || tmo;
    end

    // Stop is combinational so the controller leaves WAIT the same cycle the condition holds
    always_comb begin
        fsm_stop = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_SYNC: fsm_stop = (fsm_state == FSM_WAIT);
                ST_HOLD: fsm_stop = (hold_q == '0) && (fsm_state == FSM_WAIT);
                default: fsm_stop = 1'b0;
            endcase
        end
    end

    // Scheduler state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SYNC;
            ptr_q       <= PW'(N_REQ - 1);
            idx_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            hold_q      <= '0;
            tcnt_q      <= '0;
            fsm_start_q <= 1'b0;
            fsm_mode_q  <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            err_q       <= 1'b0;
            done_q      <= '0;
            fsm_start_q <= 1'b0;
            if (fault) begin
                // Abandon the sequence without completion and resynchronise the controller
                state_q <= ST_SYNC;
                gnt_q   <= '0;
                err_q   <= 1'b1;
                busy_q  <= 1'b1;
                tcnt_q  <= '0;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        if (fsm_state == FSM_INIT) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            tcnt_q  <= '0;
                        end
                    end
                    ST_IDLE: begin
                        if (pick_vld) begin
                            state_q     <= ST_START;
                            gnt_q       <= pick_gnt;
                            idx_q       <= pick_idx;
                            fsm_mode_q  <= req_mode[pick_idx];
                            fsm_start_q <= 1'b1;
                            busy_q      <= 1'b1;
                            tcnt_q      <= '0;
                        end
                    end
                    ST_START: begin
                        state_q <= ST_CHK;
                        tcnt_q  <= '0;
                    end
                    ST_CHK: begin
                        if (fsm_state == FSM_INIT) begin
                            state_q <= ST_DONE;
                            done_q  <= gnt_q;
                            tcnt_q  <= '0;
                        end else if (fsm_state == FSM_WAIT) begin
                            state_q <= ST_HOLD;
                            hold_q  <= hold;
                            tcnt_q  <= '0;
                        end else begin
                            tcnt_q  <= tcnt_d;
                        end
                    end
                    ST_HOLD: begin
                        if (fsm_state == FSM_INIT) begin
                            state_q <= ST_DONE;
                            done_q  <= gnt_q;
                            tcnt_q  <= '0;
                        end else begin
                            tcnt_q <= tcnt_d;
                            if (hold_q != '0) hold_q <= hold_q - 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= idx_q;
                        busy_q  <= 1'b0;
                        tcnt_q  <= '0;
                    end
                    default: begin
                        state_q <= ST_SYNC;
                        gnt_q   <= '0;
                        busy_q  <= 1'b1;
                        tcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign fsm_start = fsm_start_q;
    assign fsm_mode  = fsm_mode_q;
    assign gnt       = gnt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fsm_arb.sv
// Directed bench: fsm_arb driving the real run controller, with an override on the state feedback.
// Latency: n/a.
// Backpressure: n/a.
module tb_fsm_arb;
    import fsm_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] req_mode = '0;
    logic [3:0] hold = '0;
    logic       force_en = 1'b0;
    logic [1:0] force_val = '0;

    logic [1:0] ctl_state;
    logic [1:0] arb_state_in;
    logic       fsm_start, fsm_stop, fsm_mode, busy, err;
    logic [3:0] gnt, done;

    logic [3:0] done_acc;
    logic       stop_acc;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign arb_state_in = force_en ? force_val : ctl_state;

    fsm_arb #(.N_REQ(4), .HOLD_W(4), .TIMEOUT(15)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_mode  (req_mode),
        .hold      (hold),
        .fsm_state (arb_state_in),
        .fsm_start (fsm_start),
        .fsm_stop  (fsm_stop),
        .fsm_mode  (fsm_mode),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    fsm u_ctl (
        .clk   (clk),
        .start (fsm_start),
        .stop  (fsm_stop),
        .mode  (fsm_mode),
        .state (ctl_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        done_acc = done_acc | done;
        stop_acc = stop_acc | fsm_stop;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_acc();
        done_acc = '0;
        stop_acc = 1'b0;
    endtask

    initial begin
        clr_acc();
        // Reset state
        ticks(3);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_outs", 32'({gnt, done, fsm_start, fsm_stop, fsm_mode, err}), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_idle", 32'(busy), 32'd0);

        // Single req[0], mode=1
        req = 4'b0001; req_mode = 4'b0001; hold = 4'd3; clr_acc();
        tick();
        check("t1_start", 32'(fsm_start), 32'd1);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_ctl", 32'(ctl_state), 32'(FSM_INIT));
        req = 4'b0000;
        tick();
        check("t1_run", 32'({fsm_start, ctl_state}), 32'(FSM_RUN));
        tick();
        check("t1_init", 32'({done, ctl_state}), 32'(FSM_INIT));
        tick();
        check("t1_done", 32'(done), 32'h1);
        tick();
        check("t1_idle", 32'({gnt, busy, stop_acc}), 32'd0);

        // req[2], mode=0, hold=2
        req = 4'b0100; req_mode = 4'b0000; hold = 4'd2; clr_acc();
        tick();
        check("t2_gnt", 32'({gnt, fsm_mode}), 32'b01000);
        req = 4'b0000;
        ticks(2);
        check("t2_wait", 32'(ctl_state), 32'(FSM_WAIT));
        ticks(2);
        check("t2_nostop", 32'(stop_acc), 32'd0);
        tick();
        check("t2_stop", 32'(fsm_stop), 32'd1);
        tick();
        check("t2_back", 32'({fsm_stop, ctl_state}), 32'(FSM_INIT));
        check("t2_nodone", 32'(done_acc), 32'd0);
        tick();
        check("t2_done", 32'(done), 32'h4);
        tick();
        check("t2_idle", 32'(busy), 32'd0);

        // Constant 1111, all mode=1, from a fresh pointer
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check("t3_idle", 32'(busy), 32'd0);
        req = 4'b1111; req_mode = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t3_gnt%0d", k), 32'(gnt), 32'(1 << (k % 4)));
            ticks(3);
            check($sformatf("t3_done%0d", k), 32'(done), 32'(1 << (k % 4)));
            if (k == 4) req = 4'b0000;
            tick();
        end

        // Drop req[1] after grant; req[3] pending goes next
        req = 4'b1010; req_mode = 4'b1111;
        tick();
        check("t4_gnt1", 32'(gnt), 32'h2);
        tick();
        req = 4'b1000;
        ticks(2);
        check("t4_done1", 32'(done), 32'h2);
        ticks(2);
        check("t4_gnt3", 32'(gnt), 32'h8);
        req = 4'b0000;
        ticks(3);
        check("t4_done3", 32'(done), 32'h8);
        tick();

        // Feedback stuck at RUN in CHK -> timeout fault
        req = 4'b0001; req_mode = 4'b0001;
        tick();
        check("t5_gnt", 32'(gnt), 32'h1);
        req = 4'b0000; force_en = 1'b1; force_val = FSM_RUN; clr_acc();
        ticks(15);
        check("t5_pre", 32'({gnt, err}), 32'b00010);
        tick();
        check("t5_err", 32'({gnt, busy, err}), 32'b000011);
        check("t5_nodone", 32'(done_acc), 32'd0);
        force_en = 1'b0;
        tick();
        check("t5_recover", 32'({busy, err}), 32'd0);

        // Illegal controller code in IDLE
        force_en = 1'b1; force_val = FSM_BAD;
        tick();
        check("t6_err", 32'({busy, err}), 32'b11);
        force_en = 1'b0;
        tick();
        check("t6_recover", 32'({busy, err}), 32'd0);

        // Async reset during HOLD with the controller in WAIT
        req = 4'b0001; req_mode = 4'b0000; hold = 4'd5;
        tick();
        check("t7_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        ticks(3);
        check("t7_wait", 32'(ctl_state), 32'(FSM_WAIT));
        clr_acc();
        rst = 1'b1;
        #1;
        check("t7_rst", 32'({gnt, busy, fsm_stop}), 32'b000010);
        ticks(2);
        check("t7_held", 32'({ctl_state, stop_acc}), 32'({FSM_WAIT, 1'b0}));
        rst = 1'b0;
        #1;
        check("t7_sync", 32'({busy, fsm_stop}), 32'b11);
        tick();
        check("t7_init", 32'({busy, fsm_stop, ctl_state}), 32'({2'b10, FSM_INIT}));
        tick();
        check("t7_idle", 32'(busy), 32'd0);
        check("t7_nodone", 32'(done_acc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
